// File: rtl/litspin_gs_pkg.sv
// rtl/litspin_gs_pkg.sv - shared types and width helpers for the GS frame sequencer
package litspin_gs_pkg;

    // Sequencer top-level state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } gs_state_t;

    // Width of an index covering 0..n-1, never narrower than one bit
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int led_width(input int nb_leds_per_group);
        return width_of(nb_leds_per_group);
    endfunction

    function automatic int color_width(input int nb_colors);
        return width_of(nb_colors);
    endfunction

    function automatic int bit_sel_width(input int color_data_width, input int nb_added_lsb_bits);
        return width_of(color_data_width + nb_added_lsb_bits);
    endfunction

endpackage

// File: rtl/gs_shift_counter.sv
// rtl/gs_shift_counter.sv - nested colour/led/bit-plane down-counters with plane wrap flag
module gs_shift_counter
    import litspin_gs_pkg::*;
#(
    parameter int NB_LEDS_PER_GROUP = 16,
    parameter int NB_COLORS         = 3,
    parameter int BIT_SEL_NB        = 9
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 init_i,
    input  logic                                 advance_i,
    output logic [color_width(NB_COLORS)-1:0]    color_o,
    output logic [led_width(NB_LEDS_PER_GROUP)-1:0] led_o,
    output logic [width_of(BIT_SEL_NB)-1:0]      bit_sel_o,
    output logic                                 plane_wrap_o
);

    localparam int CW = color_width(NB_COLORS);
    localparam int LW = led_width(NB_LEDS_PER_GROUP);
    localparam int BW = width_of(BIT_SEL_NB);

    localparam logic [CW-1:0] COLOR_INIT = CW'(NB_COLORS - 1);
    localparam logic [LW-1:0] LED_INIT   = LW'(NB_LEDS_PER_GROUP - 1);
    localparam logic [BW-1:0] BIT_INIT   = BW'(BIT_SEL_NB - 1);

    logic [CW-1:0] color_q, color_d;
    logic [LW-1:0] led_q, led_d;
    logic [BW-1:0] bit_sel_q, bit_sel_d;
    logic          color_wrap, led_wrap, plane_wrap;

    // Cascaded wrap conditions: each level only wraps when all faster levels wrap too
    assign color_wrap = (color_q == '0);
    assign led_wrap   = color_wrap & (led_q == '0);
    assign plane_wrap = led_wrap & (bit_sel_q == '0);

    // Next counter values: init takes priority over advance
    always_comb begin
        color_d   = color_q;
        led_d     = led_q;
        bit_sel_d = bit_sel_q;
        if (init_i) begin
            color_d   = COLOR_INIT;
            led_d     = LED_INIT;
            bit_sel_d = BIT_INIT;
        end else if (advance_i) begin
            color_d = color_wrap ? COLOR_INIT : color_q - CW'(1);
            if (color_wrap) begin
                led_d = led_wrap ? LED_INIT : led_q - LW'(1);
            end
            if (led_wrap) begin
                bit_sel_d = plane_wrap ? BIT_INIT : bit_sel_q - BW'(1);
            end
        end
    end

    // Counter registers, reset to the first bit of a group
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_q   <= COLOR_INIT;
            led_q     <= LED_INIT;
            bit_sel_q <= BIT_INIT;
        end else begin
            color_q   <= color_d;
            led_q     <= led_d;
            bit_sel_q <= bit_sel_d;
        end
    end

    assign color_o      = color_q;
    assign led_o        = led_q;
    assign bit_sel_o    = bit_sel_q;
    assign plane_wrap_o = plane_wrap;

endmodule

// File: rtl/gs_frame_sequencer.sv
// rtl/gs_frame_sequencer.sv - greyscale shift sequencer for multiplexed LED drivers
module gs_frame_sequencer
    import litspin_gs_pkg::*;
#(
    parameter int NB_ANGLES         = 128,
    parameter int NB_LEDS_PER_GROUP = 16,
    parameter int NB_COLORS         = 3,
    parameter int NB_MUX            = 4,
    parameter int COLOR_DATA_WIDTH  = 8,
    parameter int NB_ADDED_LSB_BITS = 1,
    parameter int LAT_WRTGS_LEN     = 1,
    parameter int LAT_LATGS_LEN     = 3,
    localparam int BIT_SEL_NB       = COLOR_DATA_WIDTH + NB_ADDED_LSB_BITS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   SCLK,
    input  logic [width_of(NB_ANGLES)-1:0]         angle,
    input  logic                                   FC_en,
    output logic [color_width(NB_COLORS)-1:0]      color,
    output logic [led_width(NB_LEDS_PER_GROUP)-1:0] led,
    output logic [width_of(BIT_SEL_NB)-1:0]        bit_sel,
    output logic [NB_MUX-1:0]                      mux_en,
    output logic                                   LAT,
    output logic                                   busy,
    output logic                                   frame_done
);

    localparam int AW = width_of(NB_ANGLES);
    localparam int GW = width_of(NB_MUX);
    localparam logic [GW-1:0] LAST_GRP = GW'(NB_MUX - 1);

    gs_state_t     state_q, state_d;
    logic [GW-1:0] grp_q, grp_d;
    logic [AW-1:0] prev_angle_q;
    logic          prev_sclk_q;
    logic          frame_done_q, frame_done_d;
    logic          sclk_rise, new_angle, restart;
    logic          ctr_init, ctr_adv, plane_wrap;
    int            lat_rem, lat_len;

    assign sclk_rise = SCLK & ~prev_sclk_q;
    assign new_angle = (angle != prev_angle_q);
    assign restart   = new_angle & ~FC_en;

    gs_shift_counter #(
        .NB_LEDS_PER_GROUP (NB_LEDS_PER_GROUP),
        .NB_COLORS         (NB_COLORS),
        .BIT_SEL_NB        (BIT_SEL_NB)
    ) u_counter (
        .clk          (clk),
        .rst          (rst),
        .init_i       (ctr_init),
        .advance_i    (ctr_adv),
        .color_o      (color),
        .led_o        (led),
        .bit_sel_o    (bit_sel),
        .plane_wrap_o (plane_wrap)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Input history, group counter and frame_done pulse register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sclk_q  <= 1'b0;
            prev_angle_q <= '0;
            grp_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            prev_sclk_q  <= SCLK;
            prev_angle_q <= angle;
            grp_q        <= grp_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next state: FC_en dominates, then restart, and only then a shift edge
    always_comb begin
        state_d      = state_q;
        grp_d        = grp_q;
        ctr_init     = 1'b0;
        ctr_adv      = 1'b0;
        frame_done_d = 1'b0;
        if (FC_en) begin
            state_d  = IDLE;
            grp_d    = '0;
            ctr_init = 1'b1;
        end else if (restart) begin
            state_d  = SHIFT;
            grp_d    = '0;
            ctr_init = 1'b1;
        end else if ((state_q == SHIFT) && sclk_rise) begin
            ctr_adv = 1'b1;
            if (plane_wrap) begin
                if (grp_q == LAST_GRP) begin
                    state_d      = HOLD;
                    frame_done_d = 1'b1;
                end else begin
                    grp_d = grp_q + GW'(1);
                end
            end
        end
    end

    // LAT window: remaining bits in the plane compared with the latch length for that plane
    assign lat_rem = int'(led) * NB_COLORS + int'(color);
    assign lat_len = (bit_sel == '0) ? LAT_LATGS_LEN : LAT_WRTGS_LEN;

    // Outputs decoded from registered state; the previous group is lit while the next shifts
    always_comb begin
        busy   = 1'b0;
        mux_en = '0;
        LAT    = 1'b0;
        case (state_q)
            SHIFT: begin
                busy = 1'b1;
                for (int i = 0; i < NB_MUX - 1; i++) begin
                    if (grp_q == GW'(i + 1)) begin
                        mux_en[i] = 1'b1;
                    end
                end
                LAT = (lat_rem < lat_len);
            end
            HOLD: begin
                mux_en[NB_MUX-1] = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_gs_frame_sequencer.sv
// tb/tb_gs_frame_sequencer.sv - scoreboard testbench for gs_frame_sequencer
module tb_gs_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       SCLK;
    logic [6:0] angle;
    logic       FC_en;
    logic [1:0] color;
    logic [3:0] led;
    logic [3:0] bit_sel;
    logic [3:0] mux_en;
    logic       LAT;
    logic       busy;
    logic       frame_done;

    typedef struct {
        int c;
        int l;
        int b;
        int m;
        int lat;
        int busy;
        int fd;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];
    exp_t  mon_e;
    string mon_n;
    int    errors = 0;
    int    checks = 0;
    int    fd_cnt = 0;

    gs_frame_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .SCLK       (SCLK),
        .angle      (angle),
        .FC_en      (FC_en),
        .color      (color),
        .led        (led),
        .bit_sel    (bit_sel),
        .mux_en     (mux_en),
        .LAT        (LAT),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s: actual=%0d required=%0d", nm, fld, act, req);
        end
    endtask

    // Monitor: pops one expectation per falling edge and compares the fields that are not -1
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = nm_q.pop_front();
            if (mon_e.c    >= 0) cmp(mon_n, "color",      int'(color),      mon_e.c);
            if (mon_e.l    >= 0) cmp(mon_n, "led",        int'(led),        mon_e.l);
            if (mon_e.b    >= 0) cmp(mon_n, "bit_sel",    int'(bit_sel),    mon_e.b);
            if (mon_e.m    >= 0) cmp(mon_n, "mux_en",     int'(mux_en),     mon_e.m);
            if (mon_e.lat  >= 0) cmp(mon_n, "LAT",        int'(LAT),        mon_e.lat);
            if (mon_e.busy >= 0) cmp(mon_n, "busy",       int'(busy),       mon_e.busy);
            if (mon_e.fd   >= 0) cmp(mon_n, "frame_done", int'(frame_done), mon_e.fd);
        end
    end

    // Count frame_done pulses
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rise();
        SCLK = 1'b1;
        tick();
        SCLK = 1'b0;
        tick();
    endtask

    task automatic rises(input int k);
        repeat (k) rise();
    endtask

    task automatic expect_o(input string nm, input int c, input int l, input int b, input int m,
                            input int lat, input int bsy, input int fd);
        exp_t e;
        e.c = c; e.l = l; e.b = b; e.m = m; e.lat = lat; e.busy = bsy; e.fd = fd;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(negedge clk);
        #1;
        cmp(nm, "drain", exp_q.size(), 0);
        exp_q.delete();
        nm_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        SCLK  = 1'b0;
        angle = 7'd0;
        FC_en = 1'b0;
        repeat (2) tick();
        expect_o("reset", 2, 15, 8, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        expect_o("idle_no_angle", 2, 15, 8, 0, 0, 0, 0);

        // Frame start and first colour steps
        angle = 7'd5;
        tick();
        expect_o("start", 2, 15, 8, 0, 0, 1, 0);
        rise();
        expect_o("n1", 1, 15, 8, 0, 0, 1, 0);
        rise();
        expect_o("n2", 0, 15, 8, 0, 0, 1, 0);
        rise();
        expect_o("n3", 2, 14, 8, 0, 0, 1, 0);

        // LAT window in plane 8 and plane 0
        rises(43);
        expect_o("n46", 1, 0, 8, 0, 0, 1, 0);
        rise();
        expect_o("n47_lat", 0, 0, 8, 0, 1, 1, 0);
        rise();
        expect_o("n48", 2, 15, 7, 0, 0, 1, 0);
        rises(380);
        expect_o("n428", 0, 1, 0, 0, 0, 1, 0);
        rise();
        expect_o("n429_lat", 2, 0, 0, 0, 1, 1, 0);
        rises(2);
        expect_o("n431_lat", 0, 0, 0, 0, 1, 1, 0);
        rise();
        expect_o("n432_grp1", 2, 15, 8, 1, 0, 1, 0);

        // Last group and transition to HOLD
        rises(1295);
        expect_o("n1727", 0, 0, 0, 4, 1, 1, 0);
        SCLK = 1'b1;
        tick();
        expect_o("hold_entry", 2, 15, 8, 8, 0, 0, 1);
        SCLK = 1'b0;
        tick();
        expect_o("hold_pulse_end", 2, 15, 8, 8, 0, 0, 0);
        rises(5);
        expect_o("hold_ignore", 2, 15, 8, 8, 0, 0, 0);
        cmp("frame_pulses", "count", fd_cnt, 1);

        // Restart from HOLD, then angle change coincident with a rise
        angle = 7'd9;
        tick();
        expect_o("restart_hold", 2, 15, 8, 0, 0, 1, 0);
        rises(500);
        expect_o("n500", 0, 9, 7, 1, 0, 1, 0);
        angle = 7'd12;
        SCLK  = 1'b1;
        tick();
        expect_o("restart_coinc", 2, 15, 8, 0, 0, 1, 0);
        SCLK = 1'b0;
        tick();
        rise();
        expect_o("after_coinc", 1, 15, 8, 0, 0, 1, 0);
        rises(46);
        expect_o("k47_lat", 0, 0, 8, 0, 1, 1, 0);
        cmp("no_extra_pulse", "count", fd_cnt, 1);

        // FC_en forces IDLE and blocks restart until a later angle change
        FC_en = 1'b1;
        tick();
        expect_o("fc_idle", 2, 15, 8, 0, 0, 0, 0);
        rises(3);
        expect_o("fc_rises", 2, 15, 8, 0, 0, 0, 0);
        angle = 7'd20;
        tick();
        FC_en = 1'b0;
        tick();
        expect_o("fc_released", 2, 15, 8, 0, 0, 0, 0);
        rises(2);
        expect_o("fc_still_idle", 2, 15, 8, 0, 0, 0, 0);
        angle = 7'd21;
        tick();
        expect_o("fc_restart", 2, 15, 8, 0, 0, 1, 0);
        rises(5);
        expect_o("k5", 0, 14, 8, 0, 0, 1, 0);

        // Asynchronous reset between clock edges
        tick();
        #2;
        rst = 1'b1;
        expect_o("async_rst", 2, 15, 8, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        expect_o("post_rst_restart", 2, 15, 8, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
